alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
Host-side front end for the ALU. It deframes a byte stream (opcode, operand 1, operand 2) into an ALU command and drives the ALU's i_ready strobe. It then captures result_Hi/result_Lo on o_ready and serialises a status byte plus both results back to the host link. It sits between the host byte interface and the ALU.

Parameters:
bitness, 8, operand/result width; must be a multiple of 8; NB = bitness/8 bytes per word
add, 8'h01, ALU add opcode
sub, 8'h02, ALU sub opcode
mul, 8'h03, ALU mul opcode
div, 8'h04, ALU div opcode
timeout, 16, WAIT cycles before declaring the ALU unresponsive

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
rx_data  in  8  host command byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  sequencer accepts rx_data
tx_data  out  8  response byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  host accepts tx_data
alu_num_1  out  bitness  operand 1 to ALU
alu_num_2  out  bitness  operand 2 to ALU
alu_op_code  out  8  opcode to ALU
alu_i_ready  out  1  single-cycle command strobe to ALU
alu_result_Hi  in  bitness  ALU result high
alu_result_Lo  in  bitness  ALU result low (div remainder)
alu_o_ready  in  1  ALU result-valid strobe
busy  out  1  high in every state except GET_OP

Behaviour:
- Reset: all outputs 0, state GET_OP. rx_ready rises on the first clk after reset deasserts. Reset mid-frame or mid-response discards the partial frame and emits no further tx bytes.
- Byte handshake, both links: a transfer occurs at a posedge with valid && ready. tx_data and tx_valid hold stable while tx_valid && !tx_ready.
- rx_ready is registered and high only in GET_OP, GET_A and GET_B.
- Operands arrive MSB byte first, NB bytes each. A byte counter tracks position and wraps to 0 on each word.
- Response frame: 1 status byte, then NB result_Hi bytes MSB first, then NB result_Lo bytes MSB first. Total 1+2*NB bytes.
- Status codes: 0x00 OK, 0x01 bad opcode, 0x02 divide by zero, 0x03 timeout. On any error the result bytes are all 0x00.
- States:
  GET_OP: latch opcode into alu_op_code -> GET_A.
  GET_A: shift bytes into alu_num_1; after NB bytes -> GET_B.
  GET_B: shift bytes into alu_num_2; after NB bytes -> CHECK.
  CHECK (1 cycle): opcode not in {add,sub,mul,div} -> status 0x01. div with num_2==0 -> status 0x02. Either error skips the ALU and goes -> SEND_ST. Otherwise -> ISSUE.
  ISSUE (1 cycle): alu_i_ready=1 -> WAIT. Clear the wait counter.
  WAIT: on alu_o_ready, capture Hi/Lo, status 0x00 -> SEND_ST. If the counter reaches timeout first, status 0x03 -> SEND_ST.
  SEND_ST -> SEND_HI -> SEND_LO: each state sends its bytes. After the last result_Lo byte transfers -> GET_OP.
- Operand hold: alu_num_1, alu_num_2 and alu_op_code stay stable from ISSUE through WAIT.
- alu_i_ready is exactly one cycle per issued command and never asserted for rejected commands.
- alu_o_ready outside WAIT is ignored. If alu_o_ready coincides with the timeout cycle, alu_o_ready wins (status 0x00).
- Latency: with the registered ALU, alu_o_ready arrives the cycle after ISSUE. With rx_valid and tx_ready held high, a frame completes in (1+2*NB) rx cycles + 3 + (1+2*NB) tx cycles.
- rx bytes offered while busy are not accepted (rx_ready=0); there is no buffering.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants (add/sub/mul/div)
  - status codes 0x00–0x03
  - state encoding (GET_OP, GET_A, GET_B, CHECK, ISSUE, WAIT, SEND_ST, SEND_HI, SEND_LO)
- One natural sub-module: byte_shift_word, a NB-byte MSB-first shift register with a byte counter and done flag. Instance it for assembling each operand; a load-and-shift-out variant serialises results.

Test Plan:
- bitness=8; rx 01,05,03; behavioural ALU model -> one alu_i_ready pulse with num_1=05, num_2=03; tx 00,08,00.
- rx 04,11,04 -> tx 00,04,01 (quotient 4, remainder 1).
- rx 04,07,00 -> alu_i_ready never asserted; tx 02,00,00.
- rx 09,01,02 -> alu_i_ready never asserted; tx 01,00,00.
- Stub ALU never raises alu_o_ready; rx 01,01,01 -> tx 03,00,00 exactly timeout cycles after WAIT entry; the next frame processes normally.
- bitness=16; rx 03,01,00,00,03 with tx_ready toggling 1/0 -> tx 00,03,00,00,00. tx_data stays stable during stalls. Assert reset mid-GET_B -> no tx; the next frame starts clean.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, status and state definitions for the ALU command sequencer.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package alu_pkg;

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_MUL = 8'h03;
    localparam logic [7:0] OP_DIV = 8'h04;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_OP   = 8'h01;
    localparam logic [7:0] ST_DIV_ZERO = 8'h02;
    localparam logic [7:0] ST_TIMEOUT  = 8'h03;

    typedef enum logic [3:0] {
        GET_OP,
        GET_A,
        GET_B,
        CHECK,
        ISSUE,
        WAIT,
        SEND_ST,
        SEND_HI,
        SEND_LO
    } state_e;

endpackage

// File: rtl/byte_shift_word.sv
// NB-byte MSB-first shift register with byte counter; assembles operands or serialises results.
// Latency: word/counter update on the edge of each load or shift; done is combinational with the last shift.
// Backpressure: none internally; the owner only shifts on an accepted byte.
module byte_shift_word #(
    parameter int NB     = 1,
    parameter bit SERIAL = 1'b0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              load,
    input  logic [8*NB-1:0]                   load_word,
    input  logic                              shift,
    input  logic [7:0]                        in_byte,
    output logic [(SERIAL ? 8 : 8*NB)-1:0]    dout,
    output logic                              done
);

    localparam int            W    = 8 * NB;
    localparam int            OW   = SERIAL ? 8 : W;
    localparam int            CW   = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    logic [W-1:0]  word_q, word_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Load restarts the counter; each shift moves one byte in at the LSB and wraps the counter per word.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (load) begin
            word_d = load_word;
            cnt_d  = '0;
        end else if (shift) begin
            word_d = (word_q << 8) | W'(in_byte);
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    // Operand mode exposes the whole word; serial mode exposes only the byte about to leave.
    assign dout = word_q[W-1 -: OW];
    assign done = shift && (cnt_q == LAST);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Deframes opcode/operand bytes into one ALU command and serialises status + result bytes back.
// Latency: (1+2*NB) rx cycles + CHECK + ISSUE + WAIT, then (1+2*NB) tx cycles with no stalls.
// Backpressure: rx_ready only in GET_OP/GET_A/GET_B; tx bytes hold while tx_valid && !tx_ready.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int         bitness = 8,
    parameter logic [7:0] add     = OP_ADD,
    parameter logic [7:0] sub     = OP_SUB,
    parameter logic [7:0] mul     = OP_MUL,
    parameter logic [7:0] div     = OP_DIV,
    parameter int         timeout = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [bitness-1:0] alu_num_1,
    output logic [bitness-1:0] alu_num_2,
    output logic [7:0]         alu_op_code,
    output logic               alu_i_ready,
    input  logic [bitness-1:0] alu_result_Hi,
    input  logic [bitness-1:0] alu_result_Lo,
    input  logic               alu_o_ready,
    output logic               busy
);

    localparam int          NB        = bitness / 8;
    localparam logic [15:0] WAIT_LAST = 16'(timeout - 1);

    state_e       state_q, state_d;
    logic         rx_ready_q, rx_ready_d;
    logic [7:0]   op_q, op_d;
    logic [7:0]   status_q, status_d;
    logic [15:0]  wcnt_q, wcnt_d;

    logic               rx_fire;
    logic               a_shift, b_shift, a_done, b_done;
    logic               hi_shift, lo_shift, hi_done, lo_done;
    logic               res_load;
    logic [bitness-1:0] res_hi_val, res_lo_val;
    logic [7:0]         hi_byte, lo_byte;
    logic               op_known;

    assign rx_fire  = rx_valid && rx_ready_q;
    assign a_shift  = rx_fire && (state_q == GET_A);
    assign b_shift  = rx_fire && (state_q == GET_B);
    assign hi_shift = tx_ready && (state_q == SEND_HI);
    assign lo_shift = tx_ready && (state_q == SEND_LO);
    assign op_known = (op_q == add) || (op_q == sub) || (op_q == mul) || (op_q == div);

    byte_shift_word #(.NB(NB), .SERIAL(1'b0)) u_num_1 (
        .clk(clk), .reset(reset), .load(1'b0), .load_word('0),
        .shift(a_shift), .in_byte(rx_data), .dout(alu_num_1), .done(a_done)
    );

    byte_shift_word #(.NB(NB), .SERIAL(1'b0)) u_num_2 (
        .clk(clk), .reset(reset), .load(1'b0), .load_word('0),
        .shift(b_shift), .in_byte(rx_data), .dout(alu_num_2), .done(b_done)
    );

    byte_shift_word #(.NB(NB), .SERIAL(1'b1)) u_res_hi (
        .clk(clk), .reset(reset), .load(res_load), .load_word(res_hi_val),
        .shift(hi_shift), .in_byte(8'h00), .dout(hi_byte), .done(hi_done)
    );

    byte_shift_word #(.NB(NB), .SERIAL(1'b1)) u_res_lo (
        .clk(clk), .reset(reset), .load(res_load), .load_word(res_lo_val),
        .shift(lo_shift), .in_byte(8'h00), .dout(lo_byte), .done(lo_done)
    );

    // Frame FSM: next state, status/result capture and link outputs. Errors load all-zero results.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        status_d    = status_q;
        wcnt_d      = wcnt_q;
        res_load    = 1'b0;
        res_hi_val  = '0;
        res_lo_val  = '0;
        alu_i_ready = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        case (state_q)
            GET_OP: begin
                if (rx_fire) begin
                    op_d    = rx_data;
                    state_d = GET_A;
                end
            end
            GET_A: if (a_done) state_d = GET_B;
            GET_B: if (b_done) state_d = CHECK;
            CHECK: begin
                if (!op_known) begin
                    status_d = ST_BAD_OP;
                    res_load = 1'b1;
                    state_d  = SEND_ST;
                end else if ((op_q == div) && (alu_num_2 == '0)) begin
                    status_d = ST_DIV_ZERO;
                    res_load = 1'b1;
                    state_d  = SEND_ST;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                alu_i_ready = 1'b1;
                wcnt_d      = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                // A result arriving on the final wait cycle still counts as a success.
                if (alu_o_ready) begin
                    status_d   = ST_OK;
                    res_load   = 1'b1;
                    res_hi_val = alu_result_Hi;
                    res_lo_val = alu_result_Lo;
                    state_d    = SEND_ST;
                end else if (wcnt_q == WAIT_LAST) begin
                    status_d = ST_TIMEOUT;
                    res_load = 1'b1;
                    state_d  = SEND_ST;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            SEND_ST: begin
                tx_valid = 1'b1;
                tx_data  = status_q;
                if (tx_ready) state_d = SEND_HI;
            end
            SEND_HI: begin
                tx_valid = 1'b1;
                tx_data  = hi_byte;
                if (hi_done) state_d = SEND_LO;
            end
            SEND_LO: begin
                tx_valid = 1'b1;
                tx_data  = lo_byte;
                if (lo_done) state_d = GET_OP;
            end
            default: state_d = GET_OP;
        endcase
        rx_ready_d = (state_d == GET_OP) || (state_d == GET_A) || (state_d == GET_B);
    end

    // State registers; reset returns to an idle GET_OP with every output low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= GET_OP;
            rx_ready_q <= 1'b0;
            op_q       <= 8'h00;
            status_q   <= 8'h00;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            op_q       <= op_d;
            status_q   <= status_d;
            wcnt_q     <= wcnt_d;
        end
    end

    assign rx_ready    = rx_ready_q;
    assign alu_op_code = op_q;
    assign busy        = (state_q != GET_OP);

endmodule
